// File: rtl/mem_arbiter.sv
// mem_arbiter: clears a single-port RAM after reset, then shares it
// between two requesters with round-robin grants and routed read data.
module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rsp_valid,
  output logic [DATA_WIDTH-1:0] r0_rsp_rdata,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rsp_valid,
  output logic [DATA_WIDTH-1:0] r1_rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {S_INIT, S_RUN} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  last_q, last_d;
  logic                  pend0_q, pend0_d;
  logic                  pend1_q, pend1_d;
  logic                  gnt0, gnt1;

  // last_q holds the index of the most recently accepted requester
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_RUN && !rst) begin
      if (r0_valid && r1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = r0_valid;
        gnt1 = r1_valid;
      end
    end
  end

  assign r0_ready = gnt0;
  assign r1_ready = gnt1;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state_q == S_INIT) begin
      mem_we   = 1'b1;
      mem_addr = cnt_q;
    end else if (gnt0) begin
      mem_addr  = r0_addr;
      mem_we    = r0_we;
      mem_wdata = r0_wdata;
    end else if (gnt1) begin
      mem_addr  = r1_addr;
      mem_we    = r1_we;
      mem_wdata = r1_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    last_d      = last_q;
    pend0_d     = gnt0 & ~r0_we;
    pend1_d     = gnt1 & ~r1_we;
    if (state_q == S_INIT) begin
      if (cnt_q == LAST_ADDR) begin
        cnt_d       = '0;
        state_d     = S_RUN;
        init_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
      end
    end
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      last_q      <= 1'b1;
      pend0_q     <= 1'b0;
      pend1_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      last_q      <= last_d;
      pend0_q     <= pend0_d;
      pend1_q     <= pend1_d;
    end
  end

  // a response in flight when reset lands is dropped immediately
  assign init_done    = init_done_q;
  assign r0_rsp_valid = pend0_q & ~rst;
  assign r1_rsp_valid = pend1_q & ~rst;
  assign r0_rsp_rdata = r0_rsp_valid ? mem_rdata : '0;
  assign r1_rsp_rdata = r1_rsp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run
// against a behavioural RAM/arbiter model.
module tb_mem_arbiter;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done;
  logic          r0_valid = 1'b0, r0_ready, r0_we = 1'b0;
  logic [AW-1:0] r0_addr = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic          r0_rsp_valid;
  logic [DW-1:0] r0_rsp_rdata;
  logic          r1_valid = 1'b0, r1_ready, r1_we = 1'b0;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          r1_rsp_valid;
  logic [DW-1:0] r1_rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM with registered read, preloaded with non-zero garbage
  logic [DW-1:0] ram [DEPTH];
  logic seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++)
        ram[i] <= DW'($urandom_range(1, 255));
      seeded <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  task automatic set_r0(input logic we, input int a, input int d);
    r0_valid = 1'b1;
    r0_we = we;
    r0_addr = AW'(a);
    r0_wdata = DW'(d);
  endtask

  task automatic set_r1(input logic we, input int a, input int d);
    r1_valid = 1'b1;
    r1_we = we;
    r1_addr = AW'(a);
    r1_wdata = DW'(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    set_r0(1'b0, 5, 0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata, r0_ready, init_done,
           r0_rsp_valid} !== {1'b1, AW'(i), 8'h00, 3'b000}) begin
        n_fail++;
        $display("FAIL clear_cycle%0d: we/addr/wd/rdy/done/rv=%b/%0d/%h/%b/%b/%b required 1/%0d/00/0/0/0",
                 i, mem_we, mem_addr, mem_wdata, r0_ready,
                 init_done, r0_rsp_valid, i);
      end
      step();
    end
    @(negedge clk);
    n_checks++;
    if ({init_done, r0_ready, mem_we, mem_addr} !==
        {1'b1, 1'b1, 1'b0, AW'(5)}) begin
      n_fail++;
      $display("FAIL held_req: done/rdy/we/addr=%b/%b/%b/%0d required 1/1/0/5",
               init_done, r0_ready, mem_we, mem_addr);
    end
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if ({r0_rsp_valid, r0_rsp_rdata} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL cleared_read: rv/rd=%b/%h required 1/00",
               r0_rsp_valid, r0_rsp_rdata);
    end
    step();
  endtask

  task automatic test_write_read();
    set_r0(1'b1, 3, 'hA5);
    @(negedge clk);
    n_checks++;
    if ({r0_ready, mem_we, mem_addr, mem_wdata} !==
        {1'b1, 1'b1, AW'(3), 8'hA5}) begin
      n_fail++;
      $display("FAIL wr_cmd: rdy/we/addr/wd=%b/%b/%0d/%h required 1/1/3/a5",
               r0_ready, mem_we, mem_addr, mem_wdata);
    end
    step();
    set_r0(1'b0, 3, 0);
    @(negedge clk);
    n_checks++;
    if ({r0_ready, mem_we, mem_addr, r0_rsp_valid} !==
        {1'b1, 1'b0, AW'(3), 1'b0}) begin
      n_fail++;
      $display("FAIL rd_cmd: rdy/we/addr/rv=%b/%b/%0d/%b required 1/0/3/0",
               r0_ready, mem_we, mem_addr, r0_rsp_valid);
    end
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if ({r0_rsp_valid, r0_rsp_rdata, r1_rsp_valid} !==
        {1'b1, 8'hA5, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_rd_rsp: r0v/r0d/r1v=%b/%h/%b required 1/a5/0",
               r0_rsp_valid, r0_rsp_rdata, r1_rsp_valid);
    end
    step();
  endtask

  task automatic test_alternate();
    logic [1:0] exp_rdy, exp_rv;
    set_r0(1'b1, 1, 'h11);
    @(negedge clk);
    n_checks++;
    if (r0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL alt_wr0: r0_ready=%b required 1", r0_ready);
    end
    step();
    idle();
    set_r1(1'b1, 2, 'h22);
    @(negedge clk);
    n_checks++;
    if (r1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL alt_wr1: r1_ready=%b required 1", r1_ready);
    end
    step();
    set_r0(1'b0, 1, 0);
    set_r1(1'b0, 2, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_rv = (i == 0) ? 2'b00 : ~exp_rdy;
      n_checks++;
      if ({r0_ready, r1_ready} !== exp_rdy) begin
        n_fail++;
        $display("FAIL alt_grant%0d: rdy=%b required %b",
                 i, {r0_ready, r1_ready}, exp_rdy);
      end
      n_checks++;
      if ({r0_rsp_valid, r1_rsp_valid, r0_rsp_rdata, r1_rsp_rdata} !==
          {exp_rv, exp_rv[1] ? 8'h11 : 8'h00,
           exp_rv[0] ? 8'h22 : 8'h00}) begin
        n_fail++;
        $display("FAIL alt_rsp%0d: rv=%b d0=%h d1=%h required rv=%b",
                 i, {r0_rsp_valid, r1_rsp_valid}, r0_rsp_rdata,
                 r1_rsp_rdata, exp_rv);
      end
      step();
    end
    idle();
    @(negedge clk);
    n_checks++;
    if ({r0_rsp_valid, r1_rsp_valid, r1_rsp_rdata} !==
        {2'b01, 8'h22}) begin
      n_fail++;
      $display("FAIL alt_last: rv=%b d1=%h required 01/22",
               {r0_rsp_valid, r1_rsp_valid}, r1_rsp_rdata);
    end
    step();
  endtask

  task automatic test_cross_rw();
    set_r1(1'b1, 7, 'h3C);
    @(negedge clk);
    n_checks++;
    if ({r1_ready, mem_we, mem_addr} !== {1'b1, 1'b1, AW'(7)}) begin
      n_fail++;
      $display("FAIL cross_wr: rdy/we/addr=%b/%b/%0d required 1/1/7",
               r1_ready, mem_we, mem_addr);
    end
    step();
    idle();
    set_r0(1'b0, 7, 0);
    @(negedge clk);
    n_checks++;
    if (r0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cross_rd: r0_ready=%b required 1", r0_ready);
    end
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if ({r0_rsp_valid, r0_rsp_rdata} !== {1'b1, 8'h3C}) begin
      n_fail++;
      $display("FAIL cross_rsp: rv/rd=%b/%h required 1/3c",
               r0_rsp_valid, r0_rsp_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      set_r0(1'b1, i, 'h50 + i);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_r0(1'b0, i, 0);
      else idle();
      @(negedge clk);
      if (i < 4) begin
        n_checks++;
        if (r0_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_rdy%0d: r0_ready=%b required 1",
                   i, r0_ready);
        end
      end
      n_checks++;
      if ({r0_rsp_valid, r0_rsp_rdata} !==
          ((i >= 1 && i <= 4) ? {1'b1, DW'('h50 + i - 1)}
                              : {1'b0, 8'h00})) begin
        n_fail++;
        $display("FAIL b2b_rsp%0d: rv/rd=%b/%h", i,
                 r0_rsp_valid, r0_rsp_rdata);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_read();
    set_r0(1'b0, 2, 0);
    @(negedge clk);
    n_checks++;
    if (r0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mrd_acc: r0_ready=%b required 1", r0_ready);
    end
    step();
    idle();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (r0_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mrd_rst_rsp: r0_rsp_valid=%b required 0",
               r0_rsp_valid);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata, init_done, r0_rsp_valid,
           r1_rsp_valid} !== {1'b1, AW'(i), 8'h00, 3'b000}) begin
        n_fail++;
        $display("FAIL mrd_clear%0d: we/addr/wd/done/rv=%b/%0d/%h/%b/%b%b required 1/%0d/00/0/00",
                 i, mem_we, mem_addr, mem_wdata, init_done,
                 r0_rsp_valid, r1_rsp_valid, i);
      end
      step();
    end
    @(negedge clk);
    n_checks++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL mrd_done: init_done=%b required 1", init_done);
    end
    step();
  endtask

  task automatic test_reset_mid_init();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();
    @(negedge clk);
    n_checks++;
    if ({mem_addr, init_done} !== {AW'(8), 1'b0}) begin
      n_fail++;
      $display("FAIL mid_cnt8: addr/done=%0d/%b required 8/0",
               mem_addr, init_done);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata, init_done} !==
          {1'b1, AW'(i), 8'h00, 1'b0}) begin
        n_fail++;
        $display("FAIL mid_clear%0d: we/addr/wd/done=%b/%0d/%h/%b required 1/%0d/00/0",
                 i, mem_we, mem_addr, mem_wdata, init_done, i);
      end
      step();
    end
    @(negedge clk);
    n_checks++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_done: init_done=%b required 1", init_done);
    end
  endtask

  // Model: RAM contents as an array, last winner as an index, and
  // the response owed to each requester for the next cycle.
  task automatic test_random();
    logic [DW-1:0] m_mem [DEPTH];
    int            m_last = 1;
    int            g;
    bit            hold [2];
    logic          rwe [2];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];
    bit            ep [2];
    logic [DW-1:0] ed [2];
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [DW-1:0] e_wd;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    for (int r = 0; r < 2; r++) begin
      hold[r] = 1'b0;
      ep[r] = 1'b0;
      ed[r] = '0;
    end
    step();
    for (int c = 0; c < 300; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!hold[r] && $urandom_range(0, 9) < 7) begin
          hold[r] = 1'b1;
          rwe[r] = 1'($urandom_range(0, 1));
          ra[r] = AW'($urandom_range(0, DEPTH - 1));
          rd[r] = DW'($urandom);
        end
      end
      r0_valid = hold[0]; r0_we = rwe[0];
      r0_addr = ra[0]; r0_wdata = rd[0];
      r1_valid = hold[1]; r1_we = rwe[1];
      r1_addr = ra[1]; r1_wdata = rd[1];
      if (hold[0] && hold[1]) g = 1 - m_last;
      else if (hold[0]) g = 0;
      else if (hold[1]) g = 1;
      else g = -1;
      e_addr = (g >= 0) ? ra[g] : '0;
      e_we = (g >= 0) ? rwe[g] : 1'b0;
      e_wd = (g >= 0) ? rd[g] : '0;
      @(negedge clk);
      n_checks++;
      if ({r0_ready, r1_ready} !== {g == 0, g == 1}) begin
        n_fail++;
        $display("FAIL rnd_grant c%0d: rdy=%b required %b", c,
                 {r0_ready, r1_ready}, {g == 0, g == 1});
      end
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {e_we, e_addr, e_wd}) begin
        n_fail++;
        $display("FAIL rnd_mem c%0d: we/addr/wd=%b/%0d/%h required %b/%0d/%h",
                 c, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wd);
      end
      n_checks++;
      if ({r0_rsp_valid, r1_rsp_valid, r0_rsp_rdata, r1_rsp_rdata} !==
          {ep[0], ep[1], ep[0] ? ed[0] : 8'h00,
           ep[1] ? ed[1] : 8'h00}) begin
        n_fail++;
        $display("FAIL rnd_rsp c%0d: rv=%b%b d=%h/%h required %b%b %h/%h",
                 c, r0_rsp_valid, r1_rsp_valid, r0_rsp_rdata,
                 r1_rsp_rdata, ep[0], ep[1], ed[0], ed[1]);
      end
      ep[0] = 1'b0;
      ep[1] = 1'b0;
      if (g >= 0) begin
        m_last = g;
        hold[g] = 1'b0;
        if (rwe[g]) begin
          m_mem[ra[g]] = rd[g];
        end else begin
          ep[g] = 1'b1;
          ed[g] = m_mem[ra[g]];
        end
      end
      step();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_cross_rw();
    test_back_to_back();
    test_reset_mid_read();
    test_reset_mid_init();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
